serial_subtractor: RTL

Bit-serial unsigned subtractor computing `in_a - in_b - in_bin` over WIDTH clock cycles, LSB first, using a single full-subtractor cell and a registered borrow. It is the sequential counterpart of the lab's combinational full adder. It serves as the arithmetic datapath for the subtractor lab and as a reusable small-area subtract unit with a start/done handshake.

---
 rtl/serial_subtractor.sv | 93 +++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b - bin over WIDTH cycles, LSB first, with a single
// full-subtractor cell, a registered borrow and a start/done handshake.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_bin,
  output logic             out_busy,
  output logic             out_done,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_bout,
  output logic             out_d_bit,
  output logic             out_d_valid
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, d_q;
  logic             br_q;
  logic [CntW-1:0]  cnt_q;

  logic             a0, b0, d_bit, bo_bit;
  logic [WIDTH-1:0] d_shift;

  // Full-subtractor cell on the current LSBs and the carried borrow.
  always_comb begin
    a0      = a_q[0];
    b0      = b_q[0];
    d_bit   = a0 ^ b0 ^ br_q;
    bo_bit  = (~a0 & b0) | (~(a0 ^ b0) & br_q);
    d_shift = {d_bit, d_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      d_q         <= '0;
      br_q        <= 1'b0;
      cnt_q       <= '0;
      out_done    <= 1'b0;
      out_diff    <= '0;
      out_bout    <= 1'b0;
      out_d_bit   <= 1'b0;
      out_d_valid <= 1'b0;
    end else begin
      out_done    <= 1'b0;
      out_d_valid <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          if (in_start) begin
            a_q     <= in_a;
            b_q     <= in_b;
            br_q    <= in_bin;
            d_q     <= '0;
            cnt_q   <= '0;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          a_q         <= a_q >> 1;
          b_q         <= b_q >> 1;
          d_q         <= d_shift;
          br_q        <= bo_bit;
          cnt_q       <= cnt_q + 1'b1;
          out_d_bit   <= d_bit;
          out_d_valid <= 1'b1;
          if (cnt_q == LastCnt) begin
            out_diff <= d_shift;
            out_bout <= bo_bit;
            out_done <= 1'b1;
            state_q  <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_busy = (state_q == StRun);

endmodule
